control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/j17_pkg.sv | 54 +++++
 rtl/j17_decode.sv | 55 +++++
 rtl/control_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/j17_pkg.sv
// Shared encodings for the J17 control unit: FSM states, instruction classes,
// pcControl/writecode selects, field positions and decoded instruction kinds.
package j17_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEM       = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;

  localparam logic [1:0] CLS_ALU_R = 2'b00;
  localparam logic [1:0] CLS_ALU_I = 2'b01;
  localparam logic [1:0] CLS_MEM   = 2'b10;
  localparam logic [1:0] CLS_CTRL  = 2'b11;

  localparam logic [1:0] PC_INC   = 2'd0;
  localparam logic [1:0] PC_HOLD  = 2'd1;
  localparam logic [1:0] PC_LOAD  = 2'd2;
  localparam logic [1:0] PC_CLEAR = 2'd3;

  localparam logic [1:0] WC_ALU   = 2'd0;
  localparam logic [1:0] WC_RAM   = 2'd1;
  localparam logic [1:0] WC_IMM22 = 2'd2;
  localparam logic [1:0] WC_SW    = 2'd3;

  localparam int unsigned CLS_HI   = 31;
  localparam int unsigned CLS_LO   = 30;
  localparam int unsigned FUNC_HI  = 29;
  localparam int unsigned FUNC_LO  = 26;
  localparam int unsigned RD_HI    = 25;
  localparam int unsigned RD_LO    = 21;
  localparam int unsigned RS1_HI   = 20;
  localparam int unsigned RS1_LO   = 16;
  localparam int unsigned RS2_HI   = 15;
  localparam int unsigned RS2_LO   = 11;
  localparam int unsigned IMM16_HI = 15;
  localparam int unsigned IMM22_HI = 21;

  localparam logic [3:0] F_LOAD    = 4'd0;
  localparam logic [3:0] F_STORE   = 4'd1;
  localparam logic [3:0] F_LI      = 4'd2;
  localparam logic [3:0] F_IN      = 4'd3;
  localparam logic [3:0] F_JMP     = 4'd0;
  localparam logic [3:0] F_BEQZ    = 4'd1;
  localparam logic [3:0] F_HALT    = 4'd15;
  localparam logic [3:0] F_ALU_MAX = 4'd11;

  typedef enum logic [3:0] {
    K_NOP, K_ALU, K_LOAD, K_STORE, K_LI, K_IN, K_JMP, K_BEQZ, K_HALT
  } kind_t;

endpackage

// File: rtl/j17_decode.sv
// Combinational field extraction and class/func legality for J17 instructions.
// J17_HALT_EN enables class 11 func 15 as HALT; otherwise it decodes as a NOP.
module j17_decode
  import j17_pkg::*;
(
  input  logic [31:0] word,
  output kind_t       kind,
  output logic [1:0]  cls,
  output logic [3:0]  func,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm16,
  output logic [31:0] imm22
);

`ifdef J17_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  assign cls   = word[CLS_HI:CLS_LO];
  assign func  = word[FUNC_HI:FUNC_LO];
  assign rd    = word[RD_HI:RD_LO];
  assign rs1   = word[RS1_HI:RS1_LO];
  assign rs2   = word[RS2_HI:RS2_LO];
  assign imm16 = {16'h0000, word[IMM16_HI:0]};
  assign imm22 = {10'h000, word[IMM22_HI:0]};

  always_comb begin
    kind = K_NOP;
    case (cls)
      CLS_ALU_R, CLS_ALU_I: if (func <= F_ALU_MAX) kind = K_ALU;
      CLS_MEM: begin
        case (func)
          F_LOAD:  kind = K_LOAD;
          F_STORE: kind = K_STORE;
          F_LI:    kind = K_LI;
          F_IN:    kind = K_IN;
          default: kind = K_NOP;
        endcase
      end
      default: begin
        case (func)
          F_JMP:   kind = K_JMP;
          F_BEQZ:  kind = K_BEQZ;
          F_HALT:  kind = HALT_EN ? K_HALT : K_NOP;
          default: kind = K_NOP;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// J17 multi-cycle control FSM; all outputs are registered from the next state.
// J17_HALT_EN adds the HALT state; without it halted is tied low.
module control_unit
  import j17_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        fetch_req,
  input  logic        alu_zero,
  output logic [3:0]  opcode,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic        imControl,
  output logic        regenable,
  output logic        memwrite,
  output logic [1:0]  pcControl,
  output logic [1:0]  writecode,
  output logic        halted
);

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  logic [2:0]  state, nxt_state;
  logic [31:0] ir;
  logic [3:0]  cnt, nxt_cnt;
  logic        ir_load;

  logic [31:0] dec_word;
  kind_t       kind;
  logic [1:0]  cls;
  logic [3:0]  func;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm16, imm22;

  logic [3:0]  f_opcode, n_opcode;
  logic [31:0] f_op1, f_op2, n_op1, n_op2;
  logic        f_imc, n_imc;
  logic [1:0]  f_wc, n_wc, n_pc;
  logic        n_fetch, n_regen, n_memw;

  // Outputs are computed for the state being entered, so while accepting
  // a fetch the decoder must look at the incoming word rather than ir.
  assign dec_word = (state == S_FETCH) ? instr : ir;

  j17_decode u_decode (
    .word  (dec_word),
    .kind  (kind),
    .cls   (cls),
    .func  (func),
    .rd    (rd),
    .rs1   (rs1),
    .rs2   (rs2),
    .imm16 (imm16),
    .imm22 (imm22)
  );

  always_comb begin
    f_opcode = '0;
    f_op1    = '0;
    f_op2    = '0;
    f_imc    = 1'b0;
    f_wc     = WC_ALU;
    case (kind)
      K_ALU: begin
        f_opcode = func;
        f_op1    = 32'(rs1);
        f_imc    = (cls == CLS_ALU_I);
        f_op2    = f_imc ? imm16 : 32'(rs2);
      end
      K_LOAD, K_STORE: begin
        f_op1 = 32'(rs1);
        f_op2 = imm16;
        f_imc = 1'b1;
        f_wc  = (kind == K_LOAD) ? WC_RAM : WC_ALU;
      end
      K_LI: begin
        f_op2 = imm22;
        f_imc = 1'b1;
        f_wc  = WC_IMM22;
      end
      K_IN:   f_wc = WC_SW;
      K_JMP: begin
        f_op2 = imm16;
        f_imc = 1'b1;
      end
      K_BEQZ: begin
        f_op1 = 32'(rs1);
        f_op2 = imm16;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    ir_load   = 1'b0;
    n_regen   = 1'b0;
    n_memw    = 1'b0;
    n_pc      = PC_HOLD;
    n_opcode  = opcode;
    n_op1     = op1;
    n_op2     = op2;
    n_imc     = imControl;
    n_wc      = writecode;
    case (state)
      S_IDLE: nxt_state = S_FETCH;
      S_FETCH: begin
        if (instr_valid) begin
          nxt_state = S_DECODE;
          ir_load   = 1'b1;
          if (kind == K_NOP) n_pc = PC_INC;
        end
      end
      S_DECODE: begin
        case (kind)
          K_ALU, K_LOAD, K_STORE: nxt_state = S_EXECUTE;
          K_JMP: begin
            nxt_state = S_EXECUTE;
            n_pc      = PC_LOAD;
          end
          // alu_zero already reflects rs1: op1/opcode were driven in DECODE.
          K_BEQZ: begin
            nxt_state = S_EXECUTE;
            n_pc      = alu_zero ? PC_LOAD : PC_INC;
          end
          K_LI, K_IN: begin
            nxt_state = S_WRITEBACK;
            n_regen   = 1'b1;
            n_pc      = PC_INC;
          end
          K_HALT:  nxt_state = S_HALT;
          default: nxt_state = S_FETCH;
        endcase
      end
      S_EXECUTE: begin
        case (kind)
          K_ALU: begin
            nxt_state = S_WRITEBACK;
            n_regen   = 1'b1;
            n_pc      = PC_INC;
          end
          K_LOAD, K_STORE: begin
            nxt_state = S_MEM;
            nxt_cnt   = WAIT_LOAD;
            n_memw    = (kind == K_STORE);
            if (kind == K_STORE && WAIT_LOAD == 4'd0) n_pc = PC_INC;
          end
          default: nxt_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (cnt == 4'd0) begin
          if (kind == K_LOAD) begin
            nxt_state = S_WRITEBACK;
            n_regen   = 1'b1;
            n_pc      = PC_INC;
          end else begin
            nxt_state = S_FETCH;
          end
        end else begin
          nxt_cnt = cnt - 4'd1;
          if (kind == K_STORE && cnt == 4'd1) n_pc = PC_INC;
        end
      end
      S_WRITEBACK: nxt_state = S_FETCH;
      S_HALT:      nxt_state = S_HALT;
      default:     nxt_state = S_IDLE;
    endcase

    if (nxt_state == S_IDLE) n_pc = PC_CLEAR;
    n_fetch = (nxt_state == S_FETCH);
    if (nxt_state inside {S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK}) begin
      n_opcode = f_opcode;
      n_op1    = f_op1;
      n_op2    = f_op2;
      n_imc    = f_imc;
      n_wc     = f_wc;
    end
    // Destination index travels on op1 once the operands have been consumed.
    if (nxt_state == S_WRITEBACK) n_op1 = 32'(rd);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ir        <= '0;
      cnt       <= '0;
      fetch_req <= 1'b0;
      opcode    <= '0;
      op1       <= '0;
      op2       <= '0;
      imControl <= 1'b0;
      regenable <= 1'b0;
      memwrite  <= 1'b0;
      pcControl <= PC_CLEAR;
      writecode <= WC_ALU;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      fetch_req <= n_fetch;
      opcode    <= n_opcode;
      op1       <= n_op1;
      op2       <= n_op2;
      imControl <= n_imc;
      regenable <= n_regen;
      memwrite  <= n_memw;
      pcControl <= n_pc;
      writecode <= n_wc;
      if (ir_load) ir <= instr;
    end
  end

`ifdef J17_HALT_EN
  always_ff @(posedge clock) begin
    if (!reset_n) halted <= 1'b0;
    else          halted <= (nxt_state == S_HALT);
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit (MEM_WAIT=3), optional J17_HALT_EN.
module tb_control_unit;

  logic        clock;
  logic        reset_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_req;
  logic        alu_zero;
  logic [3:0]  opcode;
  logic [31:0] op1, op2;
  logic        imControl, regenable, memwrite, halted;
  logic [1:0]  pcControl, writecode;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  typedef struct {
    int          gap, regen_n, regen_at, memw_n, memw_at, pc0_n, pc0_at, pc1_n;
    logic [3:0]  ex_opcode;
    logic [31:0] ex_op1, ex_op2, wb_op2;
    logic        ex_imc;
    logic [1:0]  ex_pc, wc;
  } obs_t;

  control_unit #(.MEM_WAIT(3)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_req   (fetch_req),
    .alu_zero    (alu_zero),
    .opcode      (opcode),
    .op1         (op1),
    .op2         (op2),
    .imControl   (imControl),
    .regenable   (regenable),
    .memwrite    (memwrite),
    .pcControl   (pcControl),
    .writecode   (writecode),
    .halted      (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] c, input logic [3:0] f,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [15:0] imm);
    return {c, f, rd, rs1, imm};
  endfunction

  // Waits for fetch_req, presents one word, then watches until the next fetch_req.
  task automatic run_instr(input logic [31:0] w, output obs_t o);
    int i;
    bit found;
    o.gap = -1; o.regen_n = 0; o.regen_at = 0; o.memw_n = 0; o.memw_at = 0;
    o.pc0_n = 0; o.pc0_at = 0; o.pc1_n = 0;
    o.ex_opcode = 'x; o.ex_op1 = 'x; o.ex_op2 = 'x; o.wb_op2 = 'x;
    o.ex_imc = 'x; o.ex_pc = 'x; o.wc = 'x;
    for (int k = 0; k < 20 && !fetch_req; k++) step();
    instr = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr = $urandom;
    found = 1'b0;
    for (i = 1; i <= 40; i++) begin
      if (fetch_req) begin
        found = 1'b1;
        break;
      end
      if (regenable) begin o.regen_n++; o.regen_at = i; o.wc = writecode; o.wb_op2 = op2; end
      if (memwrite) begin o.memw_n++; o.memw_at = i; end
      if (pcControl == 2'd0) begin o.pc0_n++; o.pc0_at = i; end
      if (pcControl == 2'd1) o.pc1_n++;
      if (i == 2) begin
        o.ex_opcode = opcode; o.ex_op1 = op1; o.ex_op2 = op2;
        o.ex_imc = imControl; o.ex_pc = pcControl;
      end
      step();
    end
    if (found) o.gap = i - 1;
  endtask

  task automatic expect_common(input string p, input int gap, input int regen_at,
                               input int memw_n, input int pc0_n, input int pc0_at);
    expect_v({p, "_gap"}, 32'(gap));
    expect_v({p, "_regen_n"}, 32'(regen_at != 0 ? 1 : 0));
    expect_v({p, "_regen_at"}, 32'(regen_at));
    expect_v({p, "_memw_n"}, 32'(memw_n));
    expect_v({p, "_pc0_n"}, 32'(pc0_n));
    expect_v({p, "_pc0_at"}, 32'(pc0_at));
  endtask

  task automatic check_common(input obs_t o);
    chk(32'(o.gap));
    chk(32'(o.regen_n));
    chk(32'(o.regen_at));
    chk(32'(o.memw_n));
    chk(32'(o.pc0_n));
    chk(32'(o.pc0_at));
  endtask

  initial begin
    obs_t o;
    int n;
    reset_n = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    alu_zero = 1'b0;

    // Reset held for three cycles
    expect_v("rst_pc", 32'd3);
    expect_v("rst_fetch", 32'd0);
    expect_v("rst_regen", 32'd0);
    expect_v("rst_memw", 32'd0);
    expect_v("rst_halted", 32'd0);
    expect_v("rst_opcode", 32'd0);
    expect_v("rst_op1", 32'd0);
    expect_v("rst_op2", 32'd0);
    expect_v("rst_imc", 32'd0);
    expect_v("rst_wc", 32'd0);
    step(); step(); step();
    chk(32'(pcControl)); chk(32'(fetch_req)); chk(32'(regenable)); chk(32'(memwrite));
    chk(32'(halted)); chk(32'(opcode)); chk(op1); chk(op2); chk(32'(imControl));
    chk(32'(writecode));

    reset_n = 1'b1;
    instr_valid = 1'b1;
    expect_v("idle_pc", 32'd3);
    expect_v("idle_fetch", 32'd0);
    chk(32'(pcControl)); chk(32'(fetch_req));
    step();
    instr_valid = 1'b0;
    expect_v("fetch_req", 32'd1);
    expect_v("fetch_pc", 32'd1);
    chk(32'(fetch_req)); chk(32'(pcControl));

    // ALU immediate
    expect_common("alui", 3, 3, 0, 1, 3);
    expect_v("alui_opcode", 32'd1);
    expect_v("alui_op1", 32'd2);
    expect_v("alui_op2", 32'd5);
    expect_v("alui_imc", 32'd1);
    expect_v("alui_wc", 32'd0);
    expect_v("alui_pc1_n", 32'd2);
    run_instr(32'h44A2_0005, o);
    check_common(o);
    chk(32'(o.ex_opcode)); chk(o.ex_op1); chk(o.ex_op2); chk(32'(o.ex_imc));
    chk(32'(o.wc)); chk(32'(o.pc1_n));

    // ALU register, highest legal opcode
    expect_common("alur", 3, 3, 0, 1, 3);
    expect_v("alur_opcode", 32'd11);
    expect_v("alur_op1", 32'd3);
    expect_v("alur_op2", 32'd7);
    expect_v("alur_imc", 32'd0);
    run_instr(mk(2'b00, 4'd11, 5'd1, 5'd3, {5'd7, 11'd0}), o);
    check_common(o);
    chk(32'(o.ex_opcode)); chk(o.ex_op1); chk(o.ex_op2); chk(32'(o.ex_imc));

    // Load with three MEM cycles
    expect_common("load", 6, 6, 0, 1, 6);
    expect_v("load_wc", 32'd1);
    expect_v("load_pc1_n", 32'd5);
    run_instr(mk(2'b10, 4'd0, 5'd3, 5'd4, 16'h0010), o);
    check_common(o);
    chk(32'(o.wc)); chk(32'(o.pc1_n));

    // Store: one memwrite in first MEM cycle, pc increment in the last
    expect_common("store", 5, 0, 1, 1, 5);
    expect_v("store_memw_at", 32'd3);
    run_instr(mk(2'b10, 4'd1, 5'd0, 5'd7, 16'h0020), o);
    check_common(o);
    chk(32'(o.memw_at));

    // LI
    expect_common("li", 2, 2, 0, 1, 2);
    expect_v("li_wc", 32'd2);
    expect_v("li_op2", 32'h003A_BCDE);
    run_instr({2'b10, 4'd2, 4'b0000, 22'h3ABCDE}, o);
    check_common(o);
    chk(32'(o.wc)); chk(o.wb_op2);

    // IN
    expect_common("in", 2, 2, 0, 1, 2);
    expect_v("in_wc", 32'd3);
    run_instr(mk(2'b10, 4'd3, 5'd4, 5'd0, 16'h0000), o);
    check_common(o);
    chk(32'(o.wc));

    // JMP
    expect_common("jmp", 2, 0, 0, 0, 0);
    expect_v("jmp_pc", 32'd2);
    expect_v("jmp_op2", 32'h0000_00AB);
    run_instr(mk(2'b11, 4'd0, 5'd0, 5'd0, 16'h00AB), o);
    check_common(o);
    chk(32'(o.ex_pc)); chk(o.ex_op2);

    // BEQZ taken
    alu_zero = 1'b1;
    expect_common("beqz_t", 2, 0, 0, 0, 0);
    expect_v("beqz_t_pc", 32'd2);
    expect_v("beqz_t_op2", 32'h0000_1234);
    expect_v("beqz_t_op1", 32'd9);
    expect_v("beqz_t_opcode", 32'd0);
    run_instr(mk(2'b11, 4'd1, 5'd0, 5'd9, 16'h1234), o);
    check_common(o);
    chk(32'(o.ex_pc)); chk(o.ex_op2); chk(o.ex_op1); chk(32'(o.ex_opcode));

    // BEQZ not taken
    alu_zero = 1'b0;
    expect_common("beqz_n", 2, 0, 0, 1, 2);
    expect_v("beqz_n_pc", 32'd0);
    run_instr(mk(2'b11, 4'd1, 5'd0, 5'd9, 16'h1234), o);
    check_common(o);
    chk(32'(o.ex_pc));

    // Undefined combinations behave as NOPs
    expect_common("nop_mem7", 1, 0, 0, 1, 1);
    run_instr(mk(2'b10, 4'd7, 5'd1, 5'd1, 16'hFFFF), o);
    check_common(o);
    expect_common("nop_alu12", 1, 0, 0, 1, 1);
    run_instr(mk(2'b00, 4'd12, 5'd1, 5'd1, 16'h0000), o);
    check_common(o);

    // Reset asserted while a store sits in EXECUTE
    for (int k = 0; k < 20 && !fetch_req; k++) step();
    instr = mk(2'b10, 4'd1, 5'd0, 5'd2, 16'h0040);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    expect_v("rs_dec_memw", 32'd0);
    expect_v("rs_ex_memw", 32'd0);
    expect_v("rs_idle_memw", 32'd0);
    expect_v("rs_idle_pc", 32'd3);
    expect_v("rs_idle_fetch", 32'd0);
    expect_v("rs_idle_regen", 32'd0);
    expect_v("rs_after_memw", 32'd0);
    expect_v("rs_refetch", 32'd1);
    chk(32'(memwrite));
    step();
    chk(32'(memwrite));
    reset_n = 1'b0;
    step();
    chk(32'(memwrite)); chk(32'(pcControl)); chk(32'(fetch_req)); chk(32'(regenable));
    reset_n = 1'b1;
    step();
    chk(32'(memwrite)); chk(32'(fetch_req));

    // Class 11 func 15
`ifdef J17_HALT_EN
    for (int k = 0; k < 20 && !fetch_req; k++) step();
    instr = 32'hFC00_0000;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    expect_v("halt_dec_halted", 32'd0);
    expect_v("halt_cycles", 32'd20);
    chk(32'(halted));
    step();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      instr_valid = 1'b1;
      if (halted === 1'b1 && fetch_req === 1'b0 && pcControl === 2'd1) n++;
      step();
    end
    instr_valid = 1'b0;
    chk(32'(n));
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    expect_v("halt_reset_halted", 32'd0);
    chk(32'(halted));
`else
    n = 0;
    expect_common("halt_nop", 1, 0, 0, 1, 1);
    expect_v("halt_nop_halted", 32'd0);
    run_instr(32'hFC00_0000, o);
    check_common(o);
    chk(32'(halted));
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
